// File: rtl/gpu_mem_pkg.sv
// Shared types and constants for the tinyGPU memory request path.
package gpu_mem_pkg;

  localparam int N_CORES_LOG = 2;
  localparam int N_CORES     = 1 << N_CORES_LOG;

  typedef logic [15:0] mem_addr_t;
  typedef logic [15:0] mem_data_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    CAPTURE,
    DONE
  } mreq_state_t;

endpackage

// File: rtl/mem_request_unit_if.sv
// Per-core bus between the request unit (master) and the shared memory controller (slave).
interface mem_request_unit_if #(
  parameter int N_CORES = gpu_mem_pkg::N_CORES
);
  import gpu_mem_pkg::*;

  logic                      MRead;
  logic                      MWrite;
  logic                      MReady;
  logic [N_CORES-1:0]        en;
  mem_addr_t [N_CORES-1:0]   in_addr;
  mem_data_t [N_CORES-1:0]   in_data;
  mem_data_t [N_CORES-1:0]   q;

  modport master (
    output MRead, MWrite, en, in_addr, in_data,
    input  MReady, q
  );

  modport slave (
    input  MRead, MWrite, en, in_addr, in_data,
    output MReady, q
  );

endinterface

// File: rtl/mreq_lane_regs.sv
// Per-lane register bank: latches mask/address/store data on accept and
// captures controller read data into enabled lanes only.
module mreq_lane_regs #(
  parameter int N_CORES = gpu_mem_pkg::N_CORES
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i_latch,
  input  logic                                i_capture,
  input  logic [N_CORES-1:0]                  i_en,
  input  gpu_mem_pkg::mem_addr_t [N_CORES-1:0] i_addr,
  input  gpu_mem_pkg::mem_data_t [N_CORES-1:0] i_wdata,
  input  gpu_mem_pkg::mem_data_t [N_CORES-1:0] i_q,
  output logic [N_CORES-1:0]                  o_en,
  output gpu_mem_pkg::mem_addr_t [N_CORES-1:0] o_addr,
  output gpu_mem_pkg::mem_data_t [N_CORES-1:0] o_wdata,
  output gpu_mem_pkg::mem_data_t [N_CORES-1:0] o_rdata
);
  import gpu_mem_pkg::*;

  logic [N_CORES-1:0]      r_en;
  mem_addr_t [N_CORES-1:0] r_addr;
  mem_data_t [N_CORES-1:0] r_wdata;
  mem_data_t [N_CORES-1:0] r_rdata;

  // NOTE: the data banks are reset as well, because an aborted load must leave lane_rdata reading zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (i_latch) begin
        r_en    <= i_en;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      for (int i = 0; i < N_CORES; i++) begin
        if (i_capture && r_en[i]) r_rdata[i] <= i_q[i];
      end
    end
  end

  assign o_en    = r_en;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_request_unit.sv
// Core-side initiator for the shared memory controller: one load/store for all lanes.
// Optional watchdog with `error` output is enabled by defining MEM_TIMEOUT_EN.
module mem_request_unit #(
  parameter int N_CORES        = gpu_mem_pkg::N_CORES,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 op_write,
  input  logic [N_CORES-1:0]                   lane_en,
  input  gpu_mem_pkg::mem_addr_t [N_CORES-1:0] lane_addr,
  input  gpu_mem_pkg::mem_data_t [N_CORES-1:0] lane_wdata,
  output gpu_mem_pkg::mem_data_t [N_CORES-1:0] lane_rdata,
  output logic                                 busy,
  output logic                                 done,
`ifdef MEM_TIMEOUT_EN
  output logic                                 error,
`endif
  mem_request_unit_if.master                   mem
);
  import gpu_mem_pkg::*;

  if (N_CORES < 2 || (N_CORES & (N_CORES - 1)) != 0) begin : g_bad_cores
    $error("N_CORES must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  mreq_state_t             r_state;
  mreq_state_t             w_state_nxt;
  logic                    r_op_write;
  logic                    w_accept;
  logic                    w_mread;
  logic                    w_mwrite;
  logic                    w_capture;
  logic [N_CORES-1:0]      w_en_lat;
  mem_addr_t [N_CORES-1:0] w_addr_lat;
  mem_data_t [N_CORES-1:0] w_wdata_lat;

`ifdef MEM_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_error;
  logic        w_wdog_hit;
  logic        w_timeout;

  assign w_wdog_hit = (r_wdog == 16'(TIMEOUT_CYCLES - 1));
`endif

  assign w_accept = (r_state == IDLE) && start;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the case infers a latch.
    w_state_nxt = r_state;
    w_mread     = 1'b0;
    w_mwrite    = 1'b0;
    w_capture   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      // An empty mask never makes the controller drop MReady, so skip the handshake.
      IDLE:      if (start) w_state_nxt = (lane_en == '0) ? DONE : ISSUE;
      ISSUE: begin
        w_mwrite    = r_op_write;
        w_mread     = ~r_op_write;
        w_state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: if (!mem.MReady) w_state_nxt = WAIT_DONE;
      WAIT_DONE: if (mem.MReady)  w_state_nxt = r_op_write ? DONE : CAPTURE;
      CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = DONE;
      end
      DONE:      w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
`ifdef MEM_TIMEOUT_EN
    if ((r_state == WAIT_BUSY || r_state == WAIT_DONE) && w_wdog_hit) begin
      w_state_nxt = DONE;
      w_timeout   = 1'b1;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_op_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_op_write <= op_write;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // ISSUE always leads to WAIT_BUSY, so clearing here zeroes the count on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog  <= '0;
      r_error <= 1'b0;
    end else begin
      r_error <= w_timeout;
      if (r_state == ISSUE)
        r_wdog <= '0;
      else if (r_state == WAIT_BUSY || r_state == WAIT_DONE)
        r_wdog <= r_wdog + 16'd1;
    end
  end

  assign error = r_error;
`endif

  mreq_lane_regs #(
    .N_CORES (N_CORES)
  ) u_lane_regs (
    .clk       (clk),
    .reset     (reset),
    .i_latch   (w_accept),
    .i_capture (w_capture),
    .i_en      (lane_en),
    .i_addr    (lane_addr),
    .i_wdata   (lane_wdata),
    .i_q       (mem.q),
    .o_en      (w_en_lat),
    .o_addr    (w_addr_lat),
    .o_wdata   (w_wdata_lat),
    .o_rdata   (lane_rdata)
  );

  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign mem.MRead  = w_mread;
  assign mem.MWrite = w_mwrite;
  assign mem.en     = (r_state == IDLE) ? '0 : w_en_lat;
  assign mem.in_addr = w_addr_lat;
  assign mem.in_data = w_wdata_lat;

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit with a simple MReady controller model.
module tb_mem_request_unit;
  import gpu_mem_pkg::*;

  localparam int NC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic                start;
  logic                op_write;
  logic [NC-1:0]       lane_en;
  mem_addr_t [NC-1:0]  lane_addr;
  mem_data_t [NC-1:0]  lane_wdata;
  mem_data_t [NC-1:0]  lane_rdata;
  logic                busy;
  logic                done;
`ifdef MEM_TIMEOUT_EN
  logic                error;
`endif

  mem_request_unit_if #(.N_CORES(NC)) mem_bus ();

  mem_request_unit #(
    .N_CORES        (NC),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op_write   (op_write),
    .lane_en    (lane_en),
    .lane_addr  (lane_addr),
    .lane_wdata (lane_wdata),
    .lane_rdata (lane_rdata),
    .busy       (busy),
    .done       (done),
`ifdef MEM_TIMEOUT_EN
    .error      (error),
`endif
    .mem        (mem_bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int rd_pulses   = 0;
  int wr_pulses   = 0;
  int done_pulses = 0;
  int err_pulses  = 0;
  int proto_errs  = 0;
  int ack_cyc     = 1;
  int busy_cyc    = 3;
  bit ctl_hang    = 1'b0;
  logic prev_rd   = 1'b0;
  logic prev_wr   = 1'b0;

  // Protocol monitor: counts pulses, flags overlap and back-to-back requests.
  always @(negedge clk) begin
    if (mem_bus.MRead)  rd_pulses++;
    if (mem_bus.MWrite) wr_pulses++;
    if ((mem_bus.MRead && mem_bus.MWrite) || (mem_bus.MRead && prev_rd) ||
        (mem_bus.MWrite && prev_wr)) proto_errs++;
    prev_rd = mem_bus.MRead;
    prev_wr = mem_bus.MWrite;
    if (done) done_pulses++;
`ifdef MEM_TIMEOUT_EN
    if (error) err_pulses++;
`endif
  end

  // Controller model: MReady drops ack_cyc cycles after the request and
  // stays low for busy_cyc+1 cycles (or until ctl_hang is released).
  initial begin
    mem_bus.MReady = 1'b1;
    forever begin
      @(negedge clk);
      if (mem_bus.MRead || mem_bus.MWrite) begin
        @(posedge clk);
        repeat (ack_cyc - 1) @(posedge clk);
        #1 mem_bus.MReady = 1'b0;
        if (ctl_hang) begin
          wait (!ctl_hang);
          #1;
        end else begin
          repeat (busy_cyc + 1) @(posedge clk);
          #1;
        end
        mem_bus.MReady = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request from a negedge; returns start-to-done latency (0 on
  // timeout) and whether the controller bus held the latched values while busy.
  task automatic run_op(input logic wr, input logic [NC-1:0] m,
                        input mem_addr_t [NC-1:0] a, input mem_data_t [NC-1:0] d,
                        input int restart_at, output int lat, output bit stable,
                        output bit err_seen);
    lat      = 0;
    stable   = 1'b1;
    err_seen = 1'b0;
    op_write = wr;
    lane_en  = m;
    lane_addr  = a;
    lane_wdata = d;
    start    = 1'b1;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      if (c == restart_at) begin
        op_write   = ~wr;
        lane_en    = '1;
        lane_addr  = '1;
        lane_wdata = '1;
      end
      if (busy && (mem_bus.en !== m || mem_bus.in_addr !== a || mem_bus.in_data !== d))
        stable = 1'b0;
      if (done) begin
        lat = c;
`ifdef MEM_TIMEOUT_EN
        err_seen = error;
`endif
      end
    end
    start = 1'b0;
  endtask

  int lat;
  bit stab;
  bit errs;
  mem_addr_t [NC-1:0] st_addr;
  mem_data_t [NC-1:0] st_data;

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    op_write   = 1'b0;
    lane_en    = '0;
    lane_addr  = '0;
    lane_wdata = '0;
    mem_bus.q  = '0;
    repeat (3) @(negedge clk);

    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    check("rst_req",    {mem_bus.MRead, mem_bus.MWrite}, 0);
    check("rst_en",     mem_bus.en, 0);
    check("rst_addr",   mem_bus.in_addr, 0);
    check("rst_data",   mem_bus.in_data, 0);
    check("rst_rdata",  lane_rdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // Store, mask 1011, ack 1 / busy 3 -> done 7 cycles after start.
    st_addr = {16'h0040, 16'h0033, 16'h0020, 16'h0010};
    st_data = {16'h00D4, 16'h00CC, 16'h00B2, 16'h00A1};
    run_op(1'b1, 4'b1011, st_addr, st_data, 0, lat, stab, errs);
    check("store_latency", lat, 7);
    check("store_hold",    stab, 1);
    repeat (3) @(negedge clk);
    check("store_wr_pulses", wr_pulses, 1);
    check("store_rd_pulses", rd_pulses, 0);
    check("idle_en_zero",    mem_bus.en, 0);
    check("idle_addr_hold",  mem_bus.in_addr, st_addr);
    check("store_rdata",     lane_rdata, 0);

    // Full-mask load fills every lane.
    mem_bus.q = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    run_op(1'b0, 4'b1111, {16'h0103, 16'h0102, 16'h0101, 16'h0100}, '0, 0, lat, stab, errs);
    check("load_all_latency", lat, 8);
    check("load_all_hold",    stab, 1);
    @(negedge clk);
    check("load_all_rdata",   lane_rdata, 64'h4444_3333_2222_1111);

    // Partial-mask load, ack 2 / busy 1 -> 1+2+1+3 = 7; lanes 0 and 3 keep old data.
    ack_cyc  = 2;
    busy_cyc = 1;
    mem_bus.q = {16'hBEEF, 16'h5678, 16'h1234, 16'hDEAD};
    run_op(1'b0, 4'b0110, {16'h0203, 16'h0202, 16'h0201, 16'h0200}, '0, 0, lat, stab, errs);
    check("load_part_latency", lat, 7);
    @(negedge clk);
    check("load_part_rdata",   lane_rdata, 64'h4444_5678_1234_1111);
    check("load_rd_pulses",    rd_pulses, 2);

    // Empty mask: done on the very next cycle, no request.
    ack_cyc  = 1;
    busy_cyc = 3;
    mem_bus.q = '1;
    run_op(1'b0, 4'b0000, {16'h0303, 16'h0302, 16'h0301, 16'h0300}, '0, 0, lat, stab, errs);
    check("empty_latency", lat, 1);
    repeat (3) @(negedge clk);
    check("empty_no_req", rd_pulses + wr_pulses, 3);
    check("empty_rdata",  lane_rdata, 64'h4444_5678_1234_1111);

    // Second start during WAIT_DONE must be ignored.
    run_op(1'b1, 4'b0101, {16'h0503, 16'h0502, 16'h0501, 16'h0500},
           {16'h0603, 16'h0602, 16'h0601, 16'h0600}, 3, lat, stab, errs);
    check("restart_latency", lat, 7);
    check("restart_hold",    stab, 1);
    repeat (12) @(negedge clk);
    check("restart_wr_pulses", wr_pulses, 2);
    check("restart_done_cnt",  done_pulses, 5);
    check("restart_idle",      busy, 0);

    // Reset during WAIT_DONE of a load aborts without done.
    op_write   = 1'b0;
    lane_en    = 4'b1111;
    lane_addr  = {16'h0703, 16'h0702, 16'h0701, 16'h0700};
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy",  busy, 0);
    check("abort_en",    mem_bus.en, 0);
    check("abort_rdata", lane_rdata, 0);
    check("abort_done",  done, 0);
    check("abort_addr",  mem_bus.in_addr, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_done",   done_pulses, 5);
    check("abort_rd_pulses", rd_pulses, 3);

`ifdef MEM_TIMEOUT_EN
    // Seed lane data, then hang the controller: done+error 8 cycles after WAIT_BUSY entry.
    mem_bus.q = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
    run_op(1'b0, 4'b1111, '0, '0, 0, lat, stab, errs);
    check("seed_latency", lat, 8);
    check("seed_no_error", errs, 0);
    @(negedge clk);
    mem_bus.q = '1;
    ctl_hang  = 1'b1;
    run_op(1'b0, 4'b1111, {16'h0803, 16'h0802, 16'h0801, 16'h0800}, '0, 0, lat, stab, errs);
    check("timeout_latency", lat, 10);
    check("timeout_error",   errs, 1);
    @(negedge clk);
    check("timeout_rdata",   lane_rdata, 64'h0D0D_0C0C_0B0B_0A0A);
    check("timeout_err_cnt", err_pulses, 1);
    ctl_hang = 1'b0;
    repeat (5) @(negedge clk);
    check("timeout_idle", busy, 0);
`endif

    check("protocol", proto_errs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
